// File: rtl/per_bus_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
package per_bus_pkg;
  localparam int PER_AW = 8;
  localparam int PER_DW = 16;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } bus_st_e;

  typedef struct packed {
    logic [PER_AW-1:0] addr;
    logic [PER_DW-1:0] din;
    logic [1:0]        wen;
    logic              lock;
  } per_req_t;
endpackage

// File: rtl/per_bus_if.sv
// Master-side handshakes plus the peripheral bus, seen from the arbiter (slave)
// and from whatever drives the masters and the peripherals (master).
interface per_bus_if;
  import per_bus_pkg::*;

  logic              m0_req,  m1_req;
  logic [PER_AW-1:0] m0_addr, m1_addr;
  logic [PER_DW-1:0] m0_din,  m1_din;
  logic [1:0]        m0_wen,  m1_wen;
  logic              m0_lock, m1_lock;
  logic              m0_ack,  m1_ack;
  logic [PER_DW-1:0] m0_dout, m1_dout;

  logic [PER_AW-1:0] per_addr;
  logic [PER_DW-1:0] per_din;
  logic              per_en;
  logic [1:0]        per_wen;
  logic [PER_DW-1:0] per_dout;

  modport slave (
    input  m0_req, m0_addr, m0_din, m0_wen, m0_lock,
    input  m1_req, m1_addr, m1_din, m1_wen, m1_lock,
    output m0_ack, m0_dout, m1_ack, m1_dout,
    output per_addr, per_din, per_en, per_wen,
    input  per_dout
  );

  modport master (
    output m0_req, m0_addr, m0_din, m0_wen, m0_lock,
    output m1_req, m1_addr, m1_din, m1_wen, m1_lock,
    input  m0_ack, m0_dout, m1_ack, m1_dout,
    input  per_addr, per_din, per_en, per_wen,
    output per_dout
  );
endinterface

// File: rtl/per_bus_rr_pick.sv
// Two-way grant picker: round-robin against last_gnt, or fixed master-0 priority.
module per_bus_rr_pick
  import per_bus_pkg::*;
#(
  parameter bit PRIO_RR = 1'b1
) (
  input  logic [1:0] eligible,
  input  logic       last_gnt,
  output logic       valid,
  output logic       gnt
);

  always_comb begin
    valid = |eligible;
    gnt   = M_CPU;
    if (&eligible) gnt = PRIO_RR ? ~last_gnt : M_CPU;
    else           gnt = eligible[1];
  end

endmodule

// File: rtl/per_bus_arbiter.sv
// Sequences CPU and debug accesses onto the shared peripheral bus: one per_en
// cycle per access, registered read data, one-cycle ack, optional bus lock.
module per_bus_arbiter
  import per_bus_pkg::*;
#(
  parameter bit PRIO_RR = 1'b1
) (
  input  logic      mclk,
  input  logic      puc,
  per_bus_if.slave  bus
);

  bus_st_e                 st_q, st_d;
  logic                    gnt_q;
  per_req_t                cur_q;
  logic [1:0][PER_DW-1:0]  dout_q;
  logic                    last_gnt_q;
  logic                    lock_vld_q, lock_own_q;

  logic [1:0]              req;
  per_req_t [1:0]          mreq;
  logic [1:0]              elig;
  logic                    lk_vld, lk_own;
  logic                    pick_vld, pick_gnt;
  logic                    ld;
  logic                    per_on;

  assign req     = {bus.m1_req, bus.m0_req};
  assign mreq[0] = '{addr: bus.m0_addr, din: bus.m0_din, wen: bus.m0_wen, lock: bus.m0_lock};
  assign mreq[1] = '{addr: bus.m1_addr, din: bus.m1_din, wen: bus.m1_wen, lock: bus.m1_lock};

  // In DONE the lock state that matters is the one this access leaves behind,
  // so an unlocking access hands the bus over without an idle cycle.
  always_comb begin
    lk_vld = lock_vld_q;
    lk_own = lock_own_q;
    elig   = req;
    if (st_q == DONE) begin
      lk_vld      = cur_q.lock;
      lk_own      = gnt_q;
      elig[gnt_q] = 1'b0;
    end
    if (lk_vld) elig = elig & (lk_own ? 2'b10 : 2'b01);
  end

  per_bus_rr_pick #(.PRIO_RR(PRIO_RR)) u_pick (
    .eligible (elig),
    .last_gnt (last_gnt_q),
    .valid    (pick_vld),
    .gnt      (pick_gnt)
  );

  always_comb begin
    st_d = st_q;
    ld   = 1'b0;
    case (st_q)
      IDLE, DONE: begin
        if (pick_vld) begin
          st_d = BUS;
          ld   = 1'b1;
        end else begin
          st_d = IDLE;
        end
      end
      BUS:     st_d = DONE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge puc) begin
    if (puc) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_ff @(posedge mclk or posedge puc) begin
    if (puc) begin
      gnt_q      <= M_CPU;
      cur_q      <= '0;
      dout_q     <= '0;
      last_gnt_q <= M_DBG;
      lock_vld_q <= 1'b0;
      lock_own_q <= M_CPU;
    end else begin
      if (ld) begin
        gnt_q      <= pick_gnt;
        cur_q      <= mreq[pick_gnt];
        last_gnt_q <= pick_gnt;
      end
      if (st_q == BUS && cur_q.wen == 2'b00) dout_q[gnt_q] <= bus.per_dout;
      if (st_q == DONE) begin
        lock_vld_q <= cur_q.lock;
        lock_own_q <= gnt_q;
      end
    end
  end

  // Zero the bus outside BUS so it ORs cleanly with other drivers.
  assign per_on       = (st_q == BUS);
  assign bus.per_en   = per_on;
  assign bus.per_addr = per_on ? cur_q.addr : '0;
  assign bus.per_din  = per_on ? cur_q.din  : '0;
  assign bus.per_wen  = per_on ? cur_q.wen  : '0;

  assign bus.m0_ack  = (st_q == DONE) && (gnt_q == M_CPU);
  assign bus.m1_ack  = (st_q == DONE) && (gnt_q == M_DBG);
  assign bus.m0_dout = dout_q[0];
  assign bus.m1_dout = dout_q[1];

endmodule

// File: tb/tb_per_bus_arbiter.sv
// Directed bench for per_bus_arbiter: round-robin instance plus a fixed-priority one.
module tb_per_bus_arbiter;
  logic mclk = 1'b0;
  logic puc;
  always #5 mclk = ~mclk;

  per_bus_if bus();
  per_bus_if bus_fp();

  per_bus_arbiter #(.PRIO_RR(1'b1)) dut    (.mclk(mclk), .puc(puc), .bus(bus));
  per_bus_arbiter #(.PRIO_RR(1'b0)) dut_fp (.mclk(mclk), .puc(puc), .bus(bus_fp));

  function automatic logic [15:0] rom(input logic [7:0] a);
    case (a)
      8'h48:   rom = 16'hA5C3;
      8'h50:   rom = 16'h7777;
      default: rom = 16'h0000;
    endcase
  endfunction

  assign bus.per_dout    = bus.per_en    ? rom(bus.per_addr)       : 16'h0;
  assign bus_fp.per_dout = bus_fp.per_en ? {8'h5A, bus_fp.per_addr} : 16'h0;

  int en_cnt = 0, ack_cnt = 0, wr_cnt = 0;
  logic [7:0]  wr_addr = 8'h0;
  logic [15:0] wr_data = 16'h0;
  always @(posedge mclk) begin
    if (bus.per_en) en_cnt <= en_cnt + 1;
    if (bus.m0_ack || bus.m1_ack) ack_cnt <= ack_cnt + 1;
    if (bus.per_en && bus.per_wen != 2'b00) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.per_addr;
      wr_data <= bus.per_din;
    end
  end

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic m0_set(input logic r, input logic [7:0] a, input logic [15:0] d,
                        input logic [1:0] w, input logic l);
    bus.m0_req = r; bus.m0_addr = a; bus.m0_din = d; bus.m0_wen = w; bus.m0_lock = l;
  endtask

  task automatic m1_set(input logic r, input logic [7:0] a, input logic [15:0] d,
                        input logic [1:0] w, input logic l);
    bus.m1_req = r; bus.m1_addr = a; bus.m1_din = d; bus.m1_wen = w; bus.m1_lock = l;
  endtask

  function automatic logic [31:0] per_all(input logic en, input logic [1:0] w,
                                          input logic [7:0] a, input logic [15:0] d);
    per_all = {5'b0, en, w, a, d};
  endfunction

  initial begin
    int e0, w0, a0;
    puc = 1'b1;
    m0_set(1'b0, 8'h0, 16'h0, 2'b00, 1'b0);
    m1_set(1'b0, 8'h0, 16'h0, 2'b00, 1'b0);
    bus_fp.m0_req = 1'b0; bus_fp.m0_addr = 8'h0; bus_fp.m0_din = 16'h0;
    bus_fp.m0_wen = 2'b00; bus_fp.m0_lock = 1'b0;
    bus_fp.m1_req = 1'b0; bus_fp.m1_addr = 8'h0; bus_fp.m1_din = 16'h0;
    bus_fp.m1_wen = 2'b00; bus_fp.m1_lock = 1'b0;
    repeat (2) tick();

    // reset state
    chk("rst_ack",  32'({bus.m1_ack, bus.m0_ack}), 32'h0);
    chk("rst_dout", {bus.m1_dout, bus.m0_dout}, 32'h0);
    chk("rst_per",  per_all(bus.per_en, bus.per_wen, bus.per_addr, bus.per_din), 32'h0);
    chk("rst_fp",   per_all(bus_fp.per_en, bus_fp.per_wen, bus_fp.per_addr, bus_fp.per_din), 32'h0);
    puc = 1'b0;
    tick();

    // single read, BUS one cycle after the request edge, ack the next
    m0_set(1'b1, 8'h48, 16'h0, 2'b00, 1'b0);
    tick();
    chk("rd_bus", per_all(bus.per_en, bus.per_wen, bus.per_addr, bus.per_din),
        per_all(1'b1, 2'b00, 8'h48, 16'h0));
    chk("rd_noack", 32'(bus.m0_ack), 32'h0);
    tick();
    chk("rd_ack",  32'({bus.m1_ack, bus.m0_ack}), 32'h1);
    chk("rd_dout", 32'(bus.m0_dout), 32'hA5C3);
    chk("rd_enoff", 32'(bus.per_en), 32'h0);
    m0_set(1'b0, 8'h48, 16'h0, 2'b00, 1'b0);
    tick();
    chk("rd_idle", 32'({bus.per_en, bus.m1_ack, bus.m0_ack}), 32'h0);

    // fresh reset so last_gnt=1 and m0 wins the first tie
    puc = 1'b1; tick(); puc = 1'b0; tick();
    m0_set(1'b1, 8'h49, 16'h1234, 2'b11, 1'b0);
    m1_set(1'b1, 8'h48, 16'h0,    2'b00, 1'b0);
    tick();
    chk("tie_a_bus", per_all(bus.per_en, bus.per_wen, bus.per_addr, bus.per_din),
        per_all(1'b1, 2'b11, 8'h49, 16'h1234));
    tick();
    chk("tie_a_ack", 32'({bus.m1_ack, bus.m0_ack}), 32'h1);
    m0_set(1'b0, 8'h49, 16'h1234, 2'b11, 1'b0);
    tick();
    chk("tie_b_bus", per_all(bus.per_en, bus.per_wen, bus.per_addr, bus.per_din),
        per_all(1'b1, 2'b00, 8'h48, 16'h0));
    tick();
    chk("tie_b_ack",  32'({bus.m1_ack, bus.m0_ack}), 32'h2);
    chk("tie_b_dout", 32'(bus.m1_dout), 32'hA5C3);
    m1_set(1'b0, 8'h48, 16'h0, 2'b00, 1'b0);
    tick();
    chk("tie_wr", {wr_addr, 8'h0, wr_data}, {8'h49, 8'h0, 16'h1234});

    // m0 alone, then a tie: round-robin now favours m1
    m0_set(1'b1, 8'h50, 16'h0, 2'b00, 1'b0);
    tick(); tick();
    chk("m0_rd50", 32'(bus.m0_dout), 32'h7777);
    m0_set(1'b0, 8'h50, 16'h0, 2'b00, 1'b0);
    tick();
    m0_set(1'b1, 8'h48, 16'h0, 2'b00, 1'b0);
    m1_set(1'b1, 8'h50, 16'h0, 2'b00, 1'b0);
    tick();
    chk("rr_first", 32'(bus.per_addr), 32'h50);
    tick();
    chk("rr_ack1", 32'({bus.m1_ack, bus.m0_ack}), 32'h2);
    m1_set(1'b0, 8'h50, 16'h0, 2'b00, 1'b0);
    tick();
    chk("rr_second", 32'(bus.per_addr), 32'h48);
    tick();
    chk("rr_ack0", 32'({bus.m1_ack, bus.m0_ack}), 32'h1);
    m0_set(1'b0, 8'h48, 16'h0, 2'b00, 1'b0);
    tick();

    // lock: m1 locked read, m0 starves until m1 unlocks with a byte write
    m1_set(1'b1, 8'h50, 16'h0, 2'b00, 1'b1);
    tick();
    chk("lk_bus", 32'(bus.per_addr), 32'h50);
    m0_set(1'b1, 8'h48, 16'h0, 2'b00, 1'b0);
    tick();
    chk("lk_ack",  32'({bus.m1_ack, bus.m0_ack}), 32'h2);
    chk("lk_dout", 32'(bus.m1_dout), 32'h7777);
    m1_set(1'b0, 8'h50, 16'h0, 2'b00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("lk_starve", 32'({bus.per_en, bus.m0_ack}), 32'h0);
    end
    m1_set(1'b1, 8'h50, 16'h00FF, 2'b01, 1'b0);
    tick();
    chk("ul_bus", per_all(bus.per_en, bus.per_wen, bus.per_addr, bus.per_din),
        per_all(1'b1, 2'b01, 8'h50, 16'h00FF));
    tick();
    chk("ul_ack", 32'({bus.m1_ack, bus.m0_ack}), 32'h2);
    m1_set(1'b0, 8'h50, 16'h00FF, 2'b01, 1'b0);
    tick();
    chk("ul_m0_bus", per_all(bus.per_en, bus.per_wen, bus.per_addr, bus.per_din),
        per_all(1'b1, 2'b00, 8'h48, 16'h0));
    tick();
    chk("ul_m0_ack",  32'({bus.m1_ack, bus.m0_ack}), 32'h1);
    chk("ul_m0_dout", 32'(bus.m0_dout), 32'hA5C3);
    m0_set(1'b0, 8'h48, 16'h0, 2'b00, 1'b0);
    tick();

    // upper-byte write; m0_dout keeps its last read value
    e0 = en_cnt;
    m0_set(1'b1, 8'h60, 16'hBEEF, 2'b10, 1'b0);
    tick();
    chk("bw_bus", per_all(bus.per_en, bus.per_wen, bus.per_addr, bus.per_din),
        per_all(1'b1, 2'b10, 8'h60, 16'hBEEF));
    tick();
    chk("bw_off",  per_all(bus.per_en, bus.per_wen, bus.per_addr, bus.per_din), 32'h0);
    chk("bw_ack",  32'(bus.m0_ack), 32'h1);
    chk("bw_dout", 32'(bus.m0_dout), 32'hA5C3);
    m0_set(1'b0, 8'h60, 16'hBEEF, 2'b10, 1'b0);
    tick();
    chk("bw_en1", 32'(en_cnt - e0), 32'h1);

    // reset during BUS of a write: no write, no ack, bus zeroed at once
    w0 = wr_cnt;
    a0 = ack_cnt;
    m0_set(1'b1, 8'h70, 16'h1111, 2'b11, 1'b0);
    tick();
    chk("ra_bus", 32'(bus.per_en), 32'h1);
    puc = 1'b1;
    #1;
    chk("ra_zero", per_all(bus.per_en, bus.per_wen, bus.per_addr, bus.per_din), 32'h0);
    tick();
    chk("ra_noack", 32'({bus.m1_ack, bus.m0_ack}), 32'h0);
    m0_set(1'b0, 8'h70, 16'h1111, 2'b11, 1'b0);
    tick();
    puc = 1'b0;
    tick(); tick();
    chk("ra_nowr",  32'(wr_cnt - w0), 32'h0);
    chk("ra_noack2", 32'(ack_cnt - a0), 32'h0);
    m1_set(1'b1, 8'h48, 16'h0, 2'b00, 1'b0);
    tick();
    chk("ra_rd_bus", per_all(bus.per_en, bus.per_wen, bus.per_addr, bus.per_din),
        per_all(1'b1, 2'b00, 8'h48, 16'h0));
    tick();
    chk("ra_rd_ack",  32'({bus.m1_ack, bus.m0_ack}), 32'h2);
    chk("ra_rd_dout", 32'(bus.m1_dout), 32'hA5C3);
    m1_set(1'b0, 8'h48, 16'h0, 2'b00, 1'b0);
    tick();

    // idle cleanliness
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle", {3'b0, bus.m1_ack, bus.m0_ack, 27'(per_all(bus.per_en, bus.per_wen,
          bus.per_addr, bus.per_din))}, 32'h0);
    end

    // fixed priority: m0 wins a tie even right after its own grant
    bus_fp.m0_req = 1'b1; bus_fp.m0_addr = 8'h11;
    tick(); tick();
    chk("fp_solo", {15'b0, bus_fp.m0_ack, bus_fp.m0_dout}, {15'b0, 1'b1, 16'h5A11});
    bus_fp.m0_req = 1'b0;
    tick();
    bus_fp.m0_req = 1'b1; bus_fp.m0_addr = 8'h22;
    bus_fp.m1_req = 1'b1; bus_fp.m1_addr = 8'h33;
    tick();
    chk("fp_first", 32'(bus_fp.per_addr), 32'h22);
    tick();
    chk("fp_ack0", 32'({bus_fp.m1_ack, bus_fp.m0_ack}), 32'h1);
    bus_fp.m0_req = 1'b0;
    tick();
    chk("fp_second", 32'(bus_fp.per_addr), 32'h33);
    tick();
    chk("fp_ack1",  32'({bus_fp.m1_ack, bus_fp.m0_ack}), 32'h2);
    chk("fp_dout1", 32'(bus_fp.m1_dout), 32'h5A33);
    bus_fp.m1_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/per_bus_arbiter.md
# per_bus_arbiter

Two-master arbiter for the 8-bit-address peripheral bus. Master 0 (CPU execution unit) and master 1 (debug interface) share one peripheral bus. The block sequences every access as a single per_en cycle, returns registered read data with a one-cycle ack, and supports an atomic lock for read-modify-write. It sits between the masters and the OR-combined per_dout of all peripherals.

## Interface
Parameters:
- PRIO_RR, 1, 1 = round-robin between masters; 0 = fixed priority with master 0 highest.

Ports (x = 0, 1):
- mclk  in  1  main system clock; all state on rising edge
- puc  in  1  main system reset, asynchronous, active-high
- mx_req  in  1  access request; held with addr/din/wen/lock stable until mx_ack
- mx_addr  in  8  word address
- mx_din  in  16  write data
- mx_wen  in  2  byte write enables; 00 = read
- mx_lock  in  1  keep bus ownership after this access
- mx_ack  out  1  one-cycle completion pulse
- mx_dout  out  16  read data, valid with mx_ack, held until next ack to same master
- per_addr  out  8  peripheral address
- per_din  out  16  peripheral write data
- per_en  out  1  peripheral enable
- per_wen  out  2  peripheral write enables
- per_dout  in  16  peripheral read data (combinational from peripherals)

## Operation
- FSM states:
  - IDLE: no access in flight.
  - BUS: per_en high for exactly one cycle.
  - DONE: ack cycle.
- IDLE/DONE arbitration. Eligible requesters are those with req high. In DONE, the master being acked is excluded. While a lock is held, only the lock owner is eligible.
- Arbitration outcomes:
  - No eligible request: go to IDLE.
  - Otherwise: latch gnt, addr, din, wen and lock into bus registers, then go to BUS.
- Round-robin (PRIO_RR=1): grant the master not equal to last_gnt when both request. last_gnt resets to 1, so master 0 wins the first tie. PRIO_RR=0: master 0 always wins ties.
- BUS cycle:
  - Drive per_en=1 with the latched addr/din/wen.
  - Read (wen=00): capture per_dout into mgnt_dout at the closing edge.
  - Write: mgnt_dout is not updated.
  - Always go to DONE.
- DONE: mgnt_ack=1. lock_owner is updated:
  - Set to gnt if the access carried lock=1.
  - Cleared if the access carried lock=0.
- Outside BUS: per_en=0, per_wen=00, per_addr=0, per_din=0. Outputs are zeroed, not held, so the OR-bus stays clean.
- Arbiter does not decode addresses. Accesses to unmapped addresses read 0 (peripherals drive 0).

## Timing
- Reset values: state IDLE, all acks 0, m0_dout=m1_dout=0, per_* outputs 0, last_gnt=1, lock_owner none.
- puc mid-access aborts immediately:
  - No ack is issued.
  - A write that has not reached its BUS closing edge is not performed.
- Latency, req high at edge E in IDLE:
  - BUS in cycle E+1.
  - Ack in cycle E+2.
- Back-to-back throughput is one access per 2 cycles (DONE→BUS directly) when the other master or a different access is pending.
- The same master re-requesting goes BUS→DONE→IDLE→BUS (3 cycles), because its req is ignored during its own ack cycle.
- Simultaneous req from both masters: exactly one grant per arbitration. The loser's req stays pending and it is granted in the following DONE.
- A locked master deasserting req leaves the lock held. The other master stalls indefinitely until the owner issues an access with lock=0. This is intended; the debug interface is responsible for releasing the lock.
- req dropped before ack is illegal. The arbiter still completes the latched access and pulses ack.

## Structure
- Shared package per_bus_pkg:
  - state encodings IDLE/BUS/DONE (2 bits)
  - master index constants M_CPU=0 and M_DBG=1
  - PER_AW=8, PER_DW=16
- Sub-module per_bus_rr_pick: combinational two-way picker.
  - Inputs: eligible[1:0], last_gnt, PRIO_RR.
  - Outputs: valid, gnt.
- Everything else lives in per_bus_arbiter: FSM, bus registers, dout registers, lock owner.

## Test plan
- Single read. m0 reads 0x48 with per_dout model = 16'hA5C3 → per_en=1 in cycle 2 with per_addr=8'h48 and per_wen=00; m0_ack in cycle 3 with m0_dout=16'hA5C3.
- Simultaneous requests. m0 writes 16'h1234 to 0x49 (wen=11) while m1 reads 0x48 → m0 BUS first, then m1 BUS two cycles later. Next tie goes to m1 (PRIO_RR=1). With PRIO_RR=0, m0 always wins.
- Lock. m1 read 0x50 with lock=1, m0 requesting throughout → m0 starves. m1 then writes 0x50 with lock=0 (wen=01, din=16'h00FF) → m0 is granted in the DONE of that write.
- Byte write. m0 wen=10, din=16'hBEEF → per_wen=10 and per_din=16'hBEEF for exactly one cycle. m0_dout is unchanged from its previous read value.
- Reset mid-access. Assert puc during BUS of a write → no ack, no further per_en, all outputs 0. The first access after reset completes with normal latency.
- Idle cleanliness. No requests for 20 cycles → per_en, per_wen, per_addr and per_din stay 0 and no ack pulses.
